// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment decoder for the multiplexed display
// driver. Everything in here is active-high; board polarity is applied only
// at the driver's output pins.
package seg_pkg;

   typedef logic [7:0] seg_code_t;   // {dp,g,f,e,d,c,b,a}, 1 = lit

   localparam seg_code_t SEG_OFF = 8'h00;

   typedef enum logic {
      ST_BLANK,   // anti-ghosting dead time, everything dark
      ST_SHOW     // digit driven, subject to brightness PWM
   } scan_state_t;

   // Full hex set; dp (bit 7) is always left clear here and merged by the caller.
   function automatic seg_code_t seg_decode(input logic [3:0] nibble);
      seg_code_t code;
      case (nibble)
         4'h0:    code = 8'h3F;
         4'h1:    code = 8'h06;
         4'h2:    code = 8'h5B;
         4'h3:    code = 8'h4F;
         4'h4:    code = 8'h66;
         4'h5:    code = 8'h6D;
         4'h6:    code = 8'h7D;
         4'h7:    code = 8'h07;
         4'h8:    code = 8'h7F;
         4'h9:    code = 8'h6F;
         4'hA:    code = 8'h77;
         4'hB:    code = 8'h7C;
         4'hC:    code = 8'h39;
         4'hD:    code = 8'h5E;
         4'hE:    code = 8'h79;
         default: code = 8'h71;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Modulo-DIV free-running counter with a single-cycle wrap pulse. Also usable
// as a generic tick divider (LED blink etc.) by watching wrap_o only.
module seg_tick_div #(
   parameter int unsigned DIV = 8,
   parameter int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,    // synchronous clear, dominates en_i
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          wrap_o    // high while cnt is DIV-1 and counting
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear, hold, or advance with wrap at DIV-1.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/seg_mux_scan.sv
// N-digit multiplexed 7-segment scanner: per-slot dead time, 8-level PWM,
// leading-zero suppression, and a per-frame snapshot so a frame never tears.
module seg_mux_scan
   import seg_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50_000_000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned NUM_DIGITS     = 3,
   parameter int unsigned GHOST_CYCLES   = 64,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    enable_i,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic                    lzs_i,
   input  logic [2:0]              bright_i,
   output logic [7:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   dig_o,
   output logic                    frame_o
);

   localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] GHOST_LAST =
      (GHOST_CYCLES > 0) ? CNT_W'(GHOST_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   // With no dead time a slot opens directly in SHOW.
   localparam scan_state_t      SLOT_START = (GHOST_CYCLES > 0) ? ST_BLANK : ST_SHOW;
   localparam seg_code_t               SEG_POL = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0]   DIG_POL = DIG_ACTIVE_LOW ? '1 : '0;

   if (DIV < GHOST_CYCLES + 1) begin : g_bad_div
      $error("seg_mux_scan: CLK_HZ/SCAN_HZ must exceed GHOST_CYCLES");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg_mux_scan: NUM_DIGITS must be 1..8");
   end

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   seg_tick_div #(.DIV(DIV), .CW(CNT_W)) u_slot_div (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (~enable_i),
      .en_i   (1'b1),
      .cnt_o  (cnt),
      .wrap_o (wrap)
   );

   scan_state_t               state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [2:0]                pwm_q, pwm_d;
   logic [4*NUM_DIGITS-1:0]   dig_shd_q, dig_shd_d;
   logic [NUM_DIGITS-1:0]     dp_shd_q, dp_shd_d;
   logic [NUM_DIGITS-1:0]     blank_shd_q, blank_shd_d;
   logic                      lzs_shd_q, lzs_shd_d;
   seg_code_t                 seg_q, seg_d;
   logic [NUM_DIGITS-1:0]     dig_q, dig_d;
   logic                      frame_q, frame_d;

   logic                      snap;
   logic [4*NUM_DIGITS-1:0]   dig_v;
   logic [NUM_DIGITS-1:0]     dp_v, blank_v, zero_from;
   logic                      lzs_v;

   // Slot FSM: dead time at the start of every slot, then SHOW until wrap.
   always_comb begin
      state_d = state_q;
      if (!enable_i || wrap) begin
         state_d = SLOT_START;
      end else begin
         case (state_q)
            ST_BLANK: if (cnt == GHOST_LAST) state_d = ST_SHOW;
            ST_SHOW:  state_d = ST_SHOW;
            default:  state_d = SLOT_START;
         endcase
      end
   end

   // Digit index, PWM phase and frame snapshot bookkeeping.
   always_comb begin
      snap        = enable_i && (cnt == '0) && (idx_q == '0);
      idx_d       = idx_q;
      pwm_d       = pwm_q;
      dig_shd_d   = snap ? digits_i : dig_shd_q;
      dp_shd_d    = snap ? dp_i     : dp_shd_q;
      blank_shd_d = snap ? blank_i  : blank_shd_q;
      lzs_shd_d   = snap ? lzs_i    : lzs_shd_q;
      if (!enable_i) begin
         idx_d = '0;
         pwm_d = '0;
      end else begin
         if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         if (state_d == ST_BLANK)     pwm_d = '0;
         else if (state_q == ST_SHOW) pwm_d = pwm_q + 3'd1;
      end
      // The snapshot cycle already displays the freshly latched value.
      dig_v   = dig_shd_d;
      dp_v    = dp_shd_d;
      blank_v = blank_shd_d;
      lzs_v   = lzs_shd_d;
   end

   // Per-digit drive: leading-zero suppression, blanking, dp and PWM gating.
   always_comb begin
      logic       acc;
      logic       dark;
      logic       dp;
      logic [3:0] nib;
      acc = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         acc          = acc && (dig_v[4*k +: 4] == 4'h0);
         zero_from[k] = acc;
      end
      nib     = dig_v[4*idx_q +: 4];
      dp      = dp_v[idx_q];
      dark    = blank_v[idx_q] || (lzs_v && (idx_q != '0) && zero_from[idx_q]);
      seg_d   = SEG_OFF;
      dig_d   = '0;
      frame_d = snap;
      if (enable_i && (state_q == ST_SHOW) && (pwm_q <= bright_i) && (!dark || dp)) begin
         seg_d        = dark ? SEG_OFF : seg_decode(nib);
         seg_d[7]     = dp;
         dig_d[idx_q] = 1'b1;
      end
   end

   // State, shadow and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= SLOT_START;
         idx_q       <= '0;
         pwm_q       <= '0;
         // NOTE: shadows are a handful of flops, not a RAM, so they take a defined reset value.
         dig_shd_q   <= '0;
         dp_shd_q    <= '0;
         blank_shd_q <= '0;
         lzs_shd_q   <= 1'b0;
         seg_q       <= SEG_OFF;
         dig_q       <= '0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pwm_q       <= pwm_d;
         dig_shd_q   <= dig_shd_d;
         dp_shd_q    <= dp_shd_d;
         blank_shd_q <= blank_shd_d;
         lzs_shd_q   <= lzs_shd_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         frame_q     <= frame_d;
      end
   end

   assign seg_o   = seg_q ^ SEG_POL;
   assign dig_o   = dig_q ^ DIG_POL;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_mux_scan.sv
// Directed bench: scan order, dead time, snapshot coherency, async reset,
// leading-zero suppression, enable gating and brightness PWM.
module tb_seg_mux_scan;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DIV=8, 2 dead cycles, 3 digits.
   logic        rst_a = 1'b1, en_a = 1'b1, lzs_a = 1'b0;
   logic [11:0] digits_a = 12'h321;
   logic [2:0]  dp_a = 3'b000, blank_a = 3'b000, bright_a = 3'd7;
   logic [7:0]  seg_a;
   logic [2:0]  dig_a;
   logic        frame_a;

   // Instance B: DIV=16, no dead time, for brightness.
   logic        rst_b = 1'b1;
   logic [2:0]  bright_b = 3'd1;
   logic [7:0]  seg_b;
   logic [2:0]  dig_b;
   logic        frame_b;

   int n_checks = 0;
   int n_fails  = 0;

   seg_mux_scan #(
      .CLK_HZ(8000), .SCAN_HZ(1000), .NUM_DIGITS(3), .GHOST_CYCLES(2),
      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) u_dut_a (
      .clk_i(clk), .rst_i(rst_a), .enable_i(en_a), .digits_i(digits_a),
      .dp_i(dp_a), .blank_i(blank_a), .lzs_i(lzs_a), .bright_i(bright_a),
      .seg_o(seg_a), .dig_o(dig_a), .frame_o(frame_a)
   );

   seg_mux_scan #(
      .CLK_HZ(16000), .SCAN_HZ(1000), .NUM_DIGITS(3), .GHOST_CYCLES(0),
      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk_i(clk), .rst_i(rst_b), .enable_i(1'b1), .digits_i(12'h321),
      .dp_i(3'b000), .blank_i(3'b000), .lzs_i(1'b0), .bright_i(bright_b),
      .seg_o(seg_b), .dig_o(dig_b), .frame_o(frame_b)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 24-cycle frame of instance A, starting at its snapshot edge.
   task automatic run_frame(input string name,
                            input logic [2:0][7:0] seg_exp,
                            input logic [2:0][2:0] dig_exp,
                            input int chg_k, input logic [11:0] chg_val);
      for (int k = 1; k <= 24; k++) begin
         int slot;
         int c;
         tick();
         slot = (k - 1) / 8;
         c    = (k - 1) % 8;
         if (c < 2) begin
            check($sformatf("%s k=%0d dig", name, k), 8'(dig_a), 8'h07);
            check($sformatf("%s k=%0d seg", name, k), seg_a, 8'hFF);
         end else begin
            check($sformatf("%s k=%0d dig", name, k), 8'(dig_a), 8'(dig_exp[slot]));
            check($sformatf("%s k=%0d seg", name, k), seg_a, seg_exp[slot]);
         end
         check($sformatf("%s k=%0d frame", name, k), 8'(frame_a), (k == 1) ? 8'h01 : 8'h00);
         if (k == chg_k) digits_a = chg_val;
      end
   endtask

   localparam logic [2:0][2:0] DIG_SCAN = {3'b011, 3'b101, 3'b110};

   initial begin
      int on_cnt;

      // Reset state.
      tick();
      tick();
      check("reset seg", seg_a, 8'hFF);
      check("reset dig", 8'(dig_a), 8'h07);
      check("reset frame", 8'(frame_a), 8'h00);

      // Basic scan of 0x321.
      rst_a = 1'b0;
      run_frame("scan", {8'hB0, 8'hA4, 8'hF9}, DIG_SCAN, 0, 12'h000);

      // Change input during digit-1 slot: this frame still shows 3,2,1.
      run_frame("coherent", {8'hB0, 8'hA4, 8'hF9}, DIG_SCAN, 10, 12'h654);
      run_frame("new value", {8'h82, 8'h92, 8'h99}, DIG_SCAN, 0, 12'h000);

      // Async reset in the middle of a SHOW phase.
      for (int i = 0; i < 4; i++) tick();
      check("pre-reset dig", 8'(dig_a), 8'h06);
      check("pre-reset seg", seg_a, 8'h99);
      rst_a = 1'b1;
      #1;
      check("async reset seg", seg_a, 8'hFF);
      check("async reset dig", 8'(dig_a), 8'h07);
      check("async reset frame", 8'(frame_a), 8'h00);

      // Leading-zero suppression with dp on digit 1.
      digits_a = 12'h005;
      lzs_a    = 1'b1;
      dp_a     = 3'b010;
      tick();
      rst_a = 1'b0;
      run_frame("lzs", {8'hFF, 8'h7F, 8'h92}, {3'b111, 3'b101, 3'b110}, 0, 12'h000);

      // Back to 0x321, then enable low mid-frame.
      digits_a = 12'h321;
      lzs_a    = 1'b0;
      dp_a     = 3'b000;
      run_frame("restore", {8'hB0, 8'hA4, 8'hF9}, DIG_SCAN, 0, 12'h000);
      for (int i = 0; i < 12; i++) tick();
      check("pre-disable dig", 8'(dig_a), 8'h05);
      check("pre-disable seg", seg_a, 8'hA4);
      en_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("disabled %0d dig", i), 8'(dig_a), 8'h07);
         check($sformatf("disabled %0d seg", i), seg_a, 8'hFF);
         check($sformatf("disabled %0d frame", i), 8'(frame_a), 8'h00);
      end
      en_a = 1'b1;
      run_frame("re-enable", {8'hB0, 8'hA4, 8'hF9}, DIG_SCAN, 0, 12'h000);

      // Brightness 1 on instance B: on for pwm 0 and 1 of each 8 SHOW cycles.
      rst_b  = 1'b0;
      on_cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         logic on;
         tick();
         on = ((k - 1) % 8) < 2;
         check($sformatf("bright1 k=%0d dig", k), 8'(dig_b), on ? 8'h06 : 8'h07);
         check($sformatf("bright1 k=%0d seg", k), seg_b, on ? 8'hF9 : 8'hFF);
         if (k == 1) check("bright1 frame", 8'(frame_b), 8'h01);
         if (dig_b == 3'b110) on_cnt++;
      end
      check("bright1 duty", 8'(on_cnt), 8'd4);

      // Brightness 7: every cycle of digit-1 slot lit.
      bright_b = 3'd7;
      on_cnt   = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("bright7 k=%0d dig", k), 8'(dig_b), 8'h05);
         check($sformatf("bright7 k=%0d seg", k), seg_b, 8'hA4);
         if (dig_b == 3'b101) on_cnt++;
      end
      check("bright7 duty", 8'(on_cnt), 8'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
